operand_loader: RTL and testbench
=================================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 0, meaning byte order of assembly (0 = first byte into bits [7:0], 1 = first byte into bits [31:24]).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_data, input, 8 bits: serial operand byte.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data valid.
REQ-006 SHALL have port in_ready, output, 1 bit: loader can accept a byte.
REQ-007 SHALL have port out_a, output, 32 bits: assembled operand a, feeding and32 port a.
REQ-008 SHALL have port out_b, output, 32 bits: assembled operand b, feeding and32 port b.
REQ-009 SHALL have port out_valid, output, 1 bit: out_a/out_b hold a complete pair.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the pair.

Function
REQ-011 SHALL use three states: LOAD_A, LOAD_B and PRESENT.
REQ-012 SHALL accept a byte only on a rising edge where in_valid=1 and in_ready=1; in_data is ignored otherwise.
REQ-013 SHALL drive in_ready=1 in LOAD_A and LOAD_B, and in_ready=0 in PRESENT and while rst=1.
REQ-014 SHALL count accepted bytes with a 2-bit counter; LOAD_A moves to LOAD_B on the 4th accepted byte, and LOAD_B moves to PRESENT on the 4th accepted byte; the counter wraps to 0 at each transition.
REQ-015 SHALL, with MSB_FIRST=0, place byte k (k=0..3) of a word in bits [8k+7:8k]; with MSB_FIRST=1, in bits [31-8k:24-8k].
REQ-016 SHALL assemble bytes in internal shadow registers; out_a and out_b update only on the edge that enters PRESENT, so they never show a partial word.
REQ-017 SHALL assert out_valid exactly in PRESENT, starting the cycle after the 8th byte is accepted (1-cycle latency).
REQ-018 SHALL hold out_a, out_b and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL leave PRESENT for LOAD_A on an edge with out_valid=1 and out_ready=1; out_valid drops the next cycle and out_a/out_b retain their last values.
REQ-020 SHALL ignore out_ready outside PRESENT, and SHALL NOT accept an input byte in the cycle of the output handshake.
REQ-021 SHALL tolerate arbitrary gaps in in_valid without losing the byte count.

Reset
REQ-022 SHALL, on any edge with rst=1, set state to LOAD_A, counter and shadow registers to 0, out_a=0, out_b=0 and out_valid=0.
REQ-023 SHALL discard any partial load when reset occurs mid-operation; the next 8 accepted bytes form a fresh pair.
REQ-024 SHALL give reset priority over every handshake in the same cycle.

Configuration
REQ-025 SHALL, when macro OPERAND_LOADER_ABORT_EN is defined, add input port abort (1 bit); abort=1 on an edge in LOAD_A or LOAD_B returns the block to LOAD_A with counter=0 and out_* unchanged, and abort is ignored in PRESENT.
REQ-026 SHALL, when OPERAND_LOADER_ABORT_EN is undefined, have no abort port, with behaviour identical to abort tied to 0.

Structure
REQ-027 SHALL take the state encoding (LOAD_A=2'd0, LOAD_B=2'd1, PRESENT=2'd2) and constants WORD_W=32, BYTE_W=8 and BYTES_PER_WORD=4 from shared package and32_pkg.
REQ-028 SHALL place byte-to-word assembly (shift/insert by index, honouring MSB_FIRST) in a single sub-module, word_assembler, instantiated once per operand.

Verification
REQ-029 SHALL cover: bytes CC x4 then AA x4, MSB_FIRST=0 -> out_a=CCCCCCCC, out_b=AAAAAAAA, out_valid=1 one cycle after the 8th byte, and downstream and32 y=88888888.
REQ-030 SHALL cover: bytes 01..08 -> out_a=04030201, out_b=08070605; the same bytes with MSB_FIRST=1 -> out_a=01020304, out_b=05060708.
REQ-031 SHALL cover: out_ready=0 for 5 cycles in PRESENT -> out_valid=1, in_ready=0 and outputs unchanged; with out_ready=1, out_valid=0 the next cycle.
REQ-032 SHALL cover: rst=1 after 3 bytes, then bytes FF x4 and 0F x4 -> out_a=FFFFFFFF, out_b=0F0F0F0F, with no earlier bytes leaking in.
REQ-033 SHALL cover: in_valid toggled every other cycle over 8 bytes of 00 -> exactly one pair with out_a=out_b=00000000.
REQ-034 SHALL cover, with OPERAND_LOADER_ABORT_EN defined: abort after 5 bytes -> state LOAD_A, and the next 8 bytes produce a correct pair.

Source files
------------

// File: rtl/and32_pkg.sv
// Shared definitions for the and32 operand path: loader state encoding and word geometry.
package and32_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        StLoadA   = 2'd0,
        StLoadB   = 2'd1,
        StPresent = 2'd2
    } loader_state_e;

    // Bit offset of byte slot idx within a word, honouring byte order.
    function automatic logic [4:0] byte_lsb(input logic [1:0] idx, input bit msb_first);
        logic [1:0] slot;
        slot = msb_first ? (2'd3 - idx) : idx;
        return {slot, 3'b000};
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Shadow register that builds one 32-bit word from bytes written by slot index.
// word_nxt_o exposes the word including a write happening on the current edge.
module word_assembler
    import and32_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [1:0]        idx_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic [WORD_W-1:0] word_nxt_o
);

    logic [WORD_W-1:0] word_q, word_d;

    always_comb begin
        word_nxt_o = word_q;
        if (wr_en_i) begin
            word_nxt_o[byte_lsb(idx_i, MSB_FIRST) +: BYTE_W] = byte_i;
        end
    end

    always_comb begin
        word_d = clr_i ? '0 : word_nxt_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/operand_loader.sv
// Loads two 32-bit operands from a byte stream and presents them as a pair.
// Optional abort input enabled by defining OPERAND_LOADER_ABORT_EN.
module operand_loader
    import and32_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
`ifdef OPERAND_LOADER_ABORT_EN
    input  logic              abort,
`endif
    output logic              in_ready,
    output logic [WORD_W-1:0] out_a,
    output logic [WORD_W-1:0] out_b,
    output logic              out_valid,
    input  logic              out_ready
);

    loader_state_e     state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] out_a_q, out_a_d;
    logic [WORD_W-1:0] out_b_q, out_b_d;

    logic              abort_w;
    logic              accept;
    logic              wr_a, wr_b, clr_shadow, load_out;
    logic [WORD_W-1:0] word_a, word_a_nxt, word_b, word_b_nxt;

`ifdef OPERAND_LOADER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign in_ready = !rst && (state_q != StPresent);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_a       = 1'b0;
        wr_b       = 1'b0;
        clr_shadow = 1'b0;
        load_out   = 1'b0;
        unique case (state_q)
            StLoadA: begin
                if (abort_w) begin
                    cnt_d      = 2'd0;
                    clr_shadow = 1'b1;
                end else if (accept) begin
                    wr_a  = 1'b1;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = StLoadB;
                    end
                end
            end
            StLoadB: begin
                if (abort_w) begin
                    state_d    = StLoadA;
                    cnt_d      = 2'd0;
                    clr_shadow = 1'b1;
                end else if (accept) begin
                    wr_b  = 1'b1;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d  = StPresent;
                        load_out = 1'b1;
                    end
                end
            end
            StPresent: begin
                // in_ready is low here, so no byte can slip in on the handshake edge.
                if (out_ready) begin
                    state_d = StLoadA;
                end
            end
            default: begin
                state_d = StLoadA;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // The 4th byte of b lands on the same edge as the output update, so take b's next value.
    always_comb begin
        out_a_d = out_a_q;
        out_b_d = out_b_q;
        if (load_out) begin
            out_a_d = word_a;
            out_b_d = word_b_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLoadA;
            cnt_q   <= 2'd0;
            out_a_q <= '0;
            out_b_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
        end
    end

    word_assembler #(
        .MSB_FIRST (MSB_FIRST)
    ) u_asm_a (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_shadow),
        .wr_en_i    (wr_a),
        .idx_i      (cnt_q),
        .byte_i     (in_data),
        .word_o     (word_a),
        .word_nxt_o (word_a_nxt)
    );

    word_assembler #(
        .MSB_FIRST (MSB_FIRST)
    ) u_asm_b (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_shadow),
        .wr_en_i    (wr_b),
        .idx_i      (cnt_q),
        .byte_i     (in_data),
        .word_o     (word_b),
        .word_nxt_o (word_b_nxt)
    );

    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_valid = (state_q == StPresent);

    logic unused_w;
    assign unused_w = ^word_a_nxt;

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: LSB-first and MSB-first instances driven in lockstep,
// table-driven vectors plus a pair scoreboard and hand-written corner sequences.
module tb_operand_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        out_ready;
    logic        abort;
    logic        in_ready0, in_ready1;
    logic [31:0] out_a0, out_b0, out_a1, out_b1;
    logic        out_valid0, out_valid1;

    int tests = 0;
    int fails = 0;
    int pairs0 = 0;
    int pairs1 = 0;

    logic [63:0] exp_q0[$];
    logic [63:0] exp_q1[$];

    always #5 clk = ~clk;

    operand_loader #(.MSB_FIRST(1'b0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef OPERAND_LOADER_ABORT_EN
        .abort     (abort),
`endif
        .in_ready  (in_ready0),
        .out_a     (out_a0),
        .out_b     (out_b0),
        .out_valid (out_valid0),
        .out_ready (out_ready)
    );

    operand_loader #(.MSB_FIRST(1'b1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef OPERAND_LOADER_ABORT_EN
        .abort     (abort),
`endif
        .in_ready  (in_ready1),
        .out_a     (out_a1),
        .out_b     (out_b1),
        .out_valid (out_valid1),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: a pair is consumed on every edge with out_valid && out_ready.
    always @(negedge clk) begin
        if (!rst && out_valid0 && out_ready) begin
            pairs0++;
            if (exp_q0.size() == 0) check("unexpected_pair0", {out_a0, out_b0}, 64'hx);
            else check("pair0", {out_a0, out_b0}, exp_q0.pop_front());
        end
        if (!rst && out_valid1 && out_ready) begin
            pairs1++;
            if (exp_q1.size() == 0) check("unexpected_pair1", {out_a1, out_b1}, 64'hx);
            else check("pair1", {out_a1, out_b1}, exp_q1.pop_front());
        end
    end

    // Drive one byte and hold it until accepted; optional one-cycle idle gap afterwards.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int waited;
        in_data  = b;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready0 && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 20) check("in_ready_timeout", {63'd0, in_ready0}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word8(input logic [63:0] bytes, input bit gap);
        for (int k = 0; k < 8; k++) send_byte(bytes[8*k +: 8], gap);
    endtask

    typedef struct {
        logic [63:0] bytes;
        logic [31:0] a0, b0, a1, b1, y0;
    } vec_t;

    vec_t vecs [3];

    initial begin
        vecs[0] = '{64'hAAAAAAAA_CCCCCCCC, 32'hCCCCCCCC, 32'hAAAAAAAA,
                    32'hCCCCCCCC, 32'hAAAAAAAA, 32'h88888888};
        vecs[1] = '{64'h08070605_04030201, 32'h04030201, 32'h08070605,
                    32'h01020304, 32'h05060708, 32'h00030201};
        vecs[2] = '{64'h78563412_EFBEADDE, 32'hEFBEADDE, 32'h78563412,
                    32'hDEADBEEF, 32'h12345678, 32'h68162412};

        rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b1; abort = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready0}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_state0", {out_a0, out_b0}, 64'd0);
        check("reset_valid", {62'd0, out_valid0, out_valid1}, 64'd0);
        check("reset_in_ready", {62'd0, in_ready0, in_ready1}, 64'd3);
        @(posedge clk); #1;

        // Table-driven pairs, consumer always ready.
        for (int i = 0; i < 3; i++) begin
            exp_q0.push_back({vecs[i].a0, vecs[i].b0});
            exp_q1.push_back({vecs[i].a1, vecs[i].b1});
            send_word8(vecs[i].bytes, 1'b0);
            @(negedge clk);
            check("latency_valid", {62'd0, out_valid0, out_valid1}, 64'd3);
            check("and32_y", {32'd0, out_a0 & out_b0}, {32'd0, vecs[i].y0});
            check("present_in_ready", {63'd0, in_ready0}, 64'd0);
            @(posedge clk); #1;
        end

        // Backpressure: pair held for 5 cycles, stray input byte must not be taken.
        out_ready = 1'b0;
        exp_q0.push_back({vecs[1].a0, vecs[1].b0});
        exp_q1.push_back({vecs[1].a1, vecs[1].b1});
        send_word8(vecs[1].bytes, 1'b0);
        in_data  = 8'h55;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid_rdy", {62'd0, out_valid0, in_ready0}, 64'd2);
            check("hold_out0", {out_a0, out_b0}, {vecs[1].a0, vecs[1].b0});
            check("hold_out1", {out_a1, out_b1}, {vecs[1].a1, vecs[1].b1});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_hs_valid", {62'd0, out_valid0, in_ready0}, 64'd1);
        check("post_hs_retain", {out_a0, out_b0}, {vecs[1].a0, vecs[1].b0});
        @(posedge clk); #1;

        // Reset mid-load, with a byte offered during reset.
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h44;
        @(negedge clk);
        check("rst_mid_in_ready", {63'd0, in_ready0}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_clear", {out_a0, out_b0}, 64'd0);
        @(posedge clk); #1;
        exp_q0.push_back({32'hFFFFFFFF, 32'h0F0F0F0F});
        exp_q1.push_back({32'hFFFFFFFF, 32'h0F0F0F0F});
        send_word8(64'h0F0F0F0F_FFFFFFFF, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Gapped input: exactly one all-zero pair.
        begin
            int p0;
            p0 = pairs0;
            exp_q0.push_back(64'd0);
            exp_q1.push_back(64'd0);
            send_word8(64'd0, 1'b1);
            repeat (6) @(negedge clk);
            check("gap_one_pair", 64'(pairs0 - p0), 64'd1);
            check("gap_idle", {63'd0, out_valid0}, 64'd0);
            @(posedge clk); #1;
        end

`ifdef OPERAND_LOADER_ABORT_EN
        for (int k = 0; k < 5; k++) send_byte(8'h99, 1'b0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_state", {61'd0, out_valid0, in_ready0, in_ready1}, 64'd3);
        check("abort_out_kept", {out_a0, out_b0}, 64'd0);
        @(posedge clk); #1;
        exp_q0.push_back({vecs[2].a0, vecs[2].b0});
        exp_q1.push_back({vecs[2].a1, vecs[2].b1});
        send_word8(vecs[2].bytes, 1'b0);
`endif

        begin
            int waited;
            waited = 0;
            while ((exp_q0.size() != 0 || exp_q1.size() != 0) && waited < 50) begin
                waited++;
                @(posedge clk);
            end
            check("drain", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
        end
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
